// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel runs a compare-wrapped counter; shadowed config applies only at a period boundary.
module clk_div_bank #(
  parameter  int NUM_CH     = 2,
  parameter  int CNT_W      = 16,
  parameter  int RESET_DIV  = 4,
  parameter  int RESET_HIGH = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic [CNT_W-1:0]  cfg_high_i,
  output logic [NUM_CH-1:0] cfg_pending_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, div_a, high_a, div_s, high_s;
    logic             pend, clk_q, tick_q;
    logic             run, boundary, apply, wr;

    // A halted channel (div_a==0) behaves exactly like a disabled one.
    always_comb begin
      run      = en_i[i] && (div_a != '0);
      boundary = run && (cnt == div_a - CNT_W'(1));
      apply    = pend && (boundary || !run);
      wr       = cfg_we_i && (cfg_ch_i == CH_W'(i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt    <= '0;
        div_a  <= CNT_W'(RESET_DIV);
        high_a <= CNT_W'(RESET_HIGH);
        div_s  <= CNT_W'(RESET_DIV);
        high_s <= CNT_W'(RESET_HIGH);
        pend   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (run) begin
          cnt    <= boundary ? '0 : cnt + CNT_W'(1);
          clk_q  <= (cnt < high_a);
          tick_q <= (cnt == '0);
        end else begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end
        if (apply) begin
          div_a  <= div_s;
          high_a <= high_s;
          pend   <= 1'b0;
        end
        // Ordered after apply: a colliding write keeps pend set while the old shadow goes active.
        if (wr) begin
          div_s  <= cfg_div_i;
          high_s <= cfg_high_i;
          pend   <= 1'b1;
        end
      end
    end

    assign cfg_pending_o[i] = pend;
    assign clk_o[i]         = clk_q;
    assign tick_o[i]        = tick_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, glitch-free update, edge divisors,
// write collisions, enable/isolation, out-of-range writes and async reset.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [CW-1:0]  cfg_high = '0;
  logic [NCH-1:0] cfg_pending, clk_out, tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .RESET_DIV(4), .RESET_HIGH(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_div_i(cfg_div), .cfg_high_i(cfg_high), .cfg_pending_o(cfg_pending),
    .clk_o(clk_out), .tick_o(tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [1:0] ch, input int d, input int h);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = CW'(d);
    cfg_high = CW'(h);
  endtask

  task automatic do_reset();
    en = '0; cfg_we = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cfg_pending, clk_out, tick} !== '0) begin
      n_fail++; $display("FAIL reset_async: got pend=%b clk=%b tick=%b, want all 0", cfg_pending, clk_out, tick);
    end
    en = '1;
    step(); step();
    n_checks++;
    if ({cfg_pending, clk_out, tick} !== '0) begin
      n_fail++; $display("FAIL reset_held: got pend=%b clk=%b tick=%b, want all 0", cfg_pending, clk_out, tick);
    end
    en = '0; rst = 1'b0;
    step(); step();
    n_checks++;
    if ({cfg_pending, clk_out, tick} !== '0) begin
      n_fail++; $display("FAIL reset_disabled: got pend=%b clk=%b tick=%b, want all 0", cfg_pending, clk_out, tick);
    end
  endtask

  task automatic test_defaults();
    logic [7:0] ec = 8'b00110011;
    logic [7:0] et = 8'b00010001;
    do_reset();
    en = 3'b001;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0]} !== {ec[k], et[k]}) begin
        n_fail++; $display("FAIL defaults k=%0d: got clk=%b tick=%b, want clk=%b tick=%b", k, clk_out[0], tick[0], ec[k], et[k]);
      end
    end
  endtask

  task automatic test_update();
    logic [11:0] ec = 12'b000001000001;
    do_reset();
    en = 3'b001;
    step();
    set_write(2'd0, 6, 1);
    step();
    cfg_we = 1'b0;
    n_checks++;
    if ({clk_out[0], tick[0], cfg_pending[0]} !== 3'b101) begin
      n_fail++; $display("FAIL update_k1: got clk=%b tick=%b pend=%b, want 1 0 1", clk_out[0], tick[0], cfg_pending[0]);
    end
    step();
    n_checks++;
    if ({clk_out[0], tick[0], cfg_pending[0]} !== 3'b001) begin
      n_fail++; $display("FAIL update_k2: got clk=%b tick=%b pend=%b, want 0 0 1", clk_out[0], tick[0], cfg_pending[0]);
    end
    step();
    n_checks++;
    if ({clk_out[0], tick[0], cfg_pending[0]} !== 3'b000) begin
      n_fail++; $display("FAIL update_boundary: got clk=%b tick=%b pend=%b, want 0 0 0", clk_out[0], tick[0], cfg_pending[0]);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0]} !== {ec[k], ec[k]}) begin
        n_fail++; $display("FAIL update_div6 k=%0d: got clk=%b tick=%b, want clk=%b tick=%b", k, clk_out[0], tick[0], ec[k], ec[k]);
      end
    end
  endtask

  task automatic test_edges();
    logic [9:0] et = 10'b0000100001;
    do_reset();
    set_write(2'd0, 1, 1);
    step();
    cfg_we = 1'b0;
    step();
    n_checks++;
    if (cfg_pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL edges_disabled_apply: got pend=%b, want 0", cfg_pending[0]);
    end
    en = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0]} !== 2'b11) begin
        n_fail++; $display("FAIL edges_div1 k=%0d: got clk=%b tick=%b, want 1 1", k, clk_out[0], tick[0]);
      end
    end
    set_write(2'd0, 0, 1);
    step();
    cfg_we = 1'b0;
    n_checks++;
    if ({clk_out[0], tick[0], cfg_pending[0]} !== 3'b111) begin
      n_fail++; $display("FAIL edges_div0_write: got clk=%b tick=%b pend=%b, want 1 1 1", clk_out[0], tick[0], cfg_pending[0]);
    end
    step();
    n_checks++;
    if (cfg_pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL edges_div0_apply: got pend=%b, want 0", cfg_pending[0]);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0]} !== 2'b00) begin
        n_fail++; $display("FAIL edges_div0 k=%0d: got clk=%b tick=%b, want 0 0", k, clk_out[0], tick[0]);
      end
    end
    set_write(2'd0, 5, 7);
    step();
    cfg_we = 1'b0;
    step();
    n_checks++;
    if ({clk_out[0], tick[0], cfg_pending[0]} !== 3'b000) begin
      n_fail++; $display("FAIL edges_halt_apply: got clk=%b tick=%b pend=%b, want 0 0 0", clk_out[0], tick[0], cfg_pending[0]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0]} !== {1'b1, et[k]}) begin
        n_fail++; $display("FAIL edges_high_ge_div k=%0d: got clk=%b tick=%b, want 1 %b", k, clk_out[0], tick[0], et[k]);
      end
    end
  endtask

  task automatic test_collision();
    logic [9:0] ec = 10'b0001100011;
    logic [9:0] et = 10'b0000100001;
    logic [5:0] er = 6'b101001;
    do_reset();
    en = 3'b010;
    step();
    set_write(2'd1, 3, 1);
    step();
    set_write(2'd1, 5, 2);
    step();
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_pending[1] !== 1'b1) begin
      n_fail++; $display("FAIL collide_pend: got pend=%b, want 1", cfg_pending[1]);
    end
    step();
    n_checks++;
    if ({clk_out[1], cfg_pending[1]} !== 2'b00) begin
      n_fail++; $display("FAIL collide_boundary: got clk=%b pend=%b, want 0 0", clk_out[1], cfg_pending[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if ({clk_out[1], tick[1]} !== {ec[k], et[k]}) begin
        n_fail++; $display("FAIL collide_last_wins k=%0d: got clk=%b tick=%b, want clk=%b tick=%b", k, clk_out[1], tick[1], ec[k], et[k]);
      end
    end
    set_write(2'd1, 3, 1);
    step();
    cfg_we = 1'b0;
    step(); step(); step();
    set_write(2'd1, 2, 1);
    step();
    cfg_we = 1'b0;
    n_checks++;
    if ({clk_out[1], tick[1], cfg_pending[1]} !== 3'b001) begin
      n_fail++; $display("FAIL race_apply_edge: got clk=%b tick=%b pend=%b, want 0 0 1", clk_out[1], tick[1], cfg_pending[1]);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if ({clk_out[1], tick[1]} !== {er[k], er[k]}) begin
        n_fail++; $display("FAIL race_seq k=%0d: got clk=%b tick=%b, want clk=%b tick=%b", k, clk_out[1], tick[1], er[k], er[k]);
      end
      if (k == 0 || k == 2) begin
        n_checks++;
        if (cfg_pending[1] !== (k == 0)) begin
          n_fail++; $display("FAIL race_pend k=%0d: got pend=%b, want %b", k, cfg_pending[1], (k == 0));
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [13:0] ec0 = 14'b10011001100011;
    logic [13:0] et0 = 14'b10001000100001;
    logic [13:0] ec1 = 14'b11001100110011;
    logic [13:0] et1 = 14'b01000100010001;
    do_reset();
    en = 3'b011;
    for (int k = 0; k < 14; k++) begin
      if (k == 2)  en = 3'b010;
      if (k == 5)  en = 3'b011;
      if (k == 10) set_write(2'd3, 1, 1);
      if (k == 11) cfg_we = 1'b0;
      step();
      n_checks++;
      if ({clk_out[0], tick[0], clk_out[1], tick[1], clk_out[2], tick[2]} !== {ec0[k], et0[k], ec1[k], et1[k], 2'b00}) begin
        n_fail++; $display("FAIL enable_iso k=%0d: got ch0=%b%b ch1=%b%b ch2=%b%b, want ch0=%b%b ch1=%b%b ch2=00",
                           k, clk_out[0], tick[0], clk_out[1], tick[1], clk_out[2], tick[2], ec0[k], et0[k], ec1[k], et1[k]);
      end
      if (k == 10) begin
        n_checks++;
        if (cfg_pending !== 3'b000) begin
          n_fail++; $display("FAIL out_of_range_write: got pend=%b, want 000", cfg_pending);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] ec = 8'b00110011;
    logic [7:0] et = 8'b00010001;
    do_reset();
    en = 3'b001;
    set_write(2'd0, 6, 3);
    step();
    cfg_we = 1'b0;
    n_checks++;
    if ({clk_out[0], cfg_pending[0]} !== 2'b11) begin
      n_fail++; $display("FAIL areset_pre: got clk=%b pend=%b, want 1 1", clk_out[0], cfg_pending[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({cfg_pending, clk_out, tick} !== '0) begin
      n_fail++; $display("FAIL areset_immediate: got pend=%b clk=%b tick=%b, want all 0", cfg_pending, clk_out, tick);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({clk_out[0], tick[0], cfg_pending[0]} !== {ec[k], et[k], 1'b0}) begin
        n_fail++; $display("FAIL areset_default k=%0d: got clk=%b tick=%b pend=%b, want clk=%b tick=%b pend=0",
                           k, clk_out[0], tick[0], cfg_pending[0], ec[k], et[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_update();
    test_edges();
    test_collision();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock divider and clock-enable generator. Each of `NUM_CH` channels divides `clk_i` by a per-channel divisor with a programmable high time, and emits a registered divided clock and a one-cycle period-start tick. It sits beside the core clocking logic and feeds peripherals such as UART, timers and the VGA pixel enable. Divisor changes are shadowed and applied only at a period boundary, so output waveforms never glitch.

## Interface
- `NUM_CH`, default 2: number of independent channels (≥1).
- `CNT_W`, default 16: width of the divisor, high-time and counter fields.
- `RESET_DIV`, default 4: active divisor of every channel after reset.
- `RESET_HIGH`, default 2: active high time of every channel after reset.

- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  NUM_CH  per-channel run enable.
- `cfg_we_i`  in  1  configuration write strobe, one cycle per write.
- `cfg_ch_i`  in  max(1,$clog2(NUM_CH))  channel index for the write.
- `cfg_div_i`  in  CNT_W  new divisor.
- `cfg_high_i`  in  CNT_W  new high time, in `clk_i` cycles.
- `cfg_pending_o`  out  NUM_CH  shadow value written but not yet applied.
- `clk_o`  out  NUM_CH  divided clock per channel, registered.
- `tick_o`  out  NUM_CH  one-cycle pulse at each period start, registered.

## Operation
- Per-channel state:
  - `cnt` (CNT_W bits)
  - active `div_a` and `high_a`
  - shadow `div_s` and `high_s`
  - `pend`
- Reset values, all channels:
  - `cnt=0`, `div_a=div_s=RESET_DIV`, `high_a=high_s=RESET_HIGH`, `pend=0`
  - `clk_o=0`, `tick_o=0`, `cfg_pending_o=0`
- Write: when `cfg_we_i=1` and `cfg_ch_i<NUM_CH`, the selected channel takes `div_s<=cfg_div_i`, `high_s<=cfg_high_i`, `pend<=1`.
  - Writes with `cfg_ch_i≥NUM_CH` are ignored.
  - A write while `pend=1` overwrites the shadow (last write wins).
- Boundary, for a running channel: `en_i=1`, `div_a≥1`, `cnt==div_a-1`.
- Run (`en_i=1`, `div_a≥1`), on every edge:
  - `cnt <= boundary ? 0 : cnt+1`
  - `clk_o <= (cnt < high_a)`
  - `tick_o <= (cnt==0)`
- Apply: on an edge where `pend=1` and (boundary, or `en_i=0`, or `div_a==0`):
  - `div_a<=div_s`, `high_a<=high_s`, `pend<=0`.
- Apply racing a write: if the apply edge coincides with a write to the same channel, the old shadow is applied and the new write lands in the shadow with `pend` left at 1.
- Disabled (`en_i=0`): `cnt<=0`, `clk_o<=0`, `tick_o<=0`.
  - Re-enabling always starts at phase 0.
- Halted (`div_a==0`, any `en_i`): same as disabled.
- Arithmetic: the counter wraps by compare only and never overflows.
  - `high_a≥div_a` gives a constant-high `clk_o`.
  - `high_a==0` gives a constant-low `clk_o`; `tick_o` still pulses.
  - `div_a==1` gives `cnt` stuck at 0, `tick_o=1` every cycle, and `clk_o=(high_a≥1)`.
- Channels are fully independent; `cfg_pending_o[i]=pend[i]`.

## Timing
- Outputs lag `cnt` by one edge.
- First edge with `en_i=1` after reset or re-enable: `clk_o=1` if `high_a>0`, and `tick_o=1`.
- Period is exactly `div_a` cycles, with `clk_o` high for `min(high_a,div_a)` cycles starting at the tick.
- Reconfiguration latency:
  - A written value governs the channel starting with the first `cnt` value after the next boundary, i.e. the new period's `tick_o` edge.
  - Worst case `div_a+1` cycles after the write.
  - When the channel is disabled or halted, it applies on the edge after the write.
- `rst_i` asserted mid-period forces all state and outputs to reset values immediately (asynchronously). Pending writes are lost.

## Test plan
- **Reset defaults:**
  - Stimulus: reset, then `en_i=1`.
  - Required: `clk_o` shows pattern 1,1,0,0 repeating; `tick_o` pulses every 4 cycles starting on the first edge.
- **Glitch-free update:**
  - Stimulus: mid-period write of ch0 `div=6, high=1`.
  - Required: the current 4-cycle period completes unchanged, `cfg_pending_o[0]` stays 1 until the boundary, then `clk_o` is 1 high / 5 low.
- **Edge cases:**
  - Stimulus: `div=1, high=1`. Required: `clk_o` constantly 1, `tick_o` constantly 1.
  - Stimulus: `div=0`. Required: `clk_o=0`, `tick_o=0`.
  - Stimulus: `div=5, high=7`. Required: `clk_o` constant high, tick every 5 cycles.
- **Write collisions:**
  - Stimulus: two writes to ch1 back-to-back before a boundary. Required: only the second takes effect.
  - Stimulus: a write on the exact apply edge. Required: `pend` remains 1 and the new value applies at the following boundary.
- **Enable and isolation:**
  - Stimulus: drop `en_i[0]` for 3 cycles mid-period. Required: ch0 outputs drop to 0 and it restarts at phase 0; ch1 is undisturbed.
  - Stimulus: write with out-of-range `cfg_ch_i`. Required: no state change.
- **Async reset:**
  - Stimulus: assert `rst_i` between edges while a write is pending. Required: outputs drop to 0 immediately, pending cleared, `RESET_DIV` restored.
